// File: rtl/uart_frame_rx_pkg.sv
// Shared constants and types for the UART frame receiver (and its transmitter twin).
package uart_frame_rx_pkg;

    localparam logic [7:0] FRAME_TERM = 8'hF0;
    localparam int         MAX_BYTES  = 50;
    localparam int         FRAME_W    = 400;
    localparam int         NUM_W      = 6;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Line input and frame-level outputs of the receiver; slave = receiver, master = line/application side.
interface uart_frame_rx_if;
    import uart_frame_rx_pkg::*;

    logic               rx;
    logic [FRAME_W-1:0] data;
    logic [NUM_W-1:0]   num;
    logic               valid;
    logic               err;
    logic               busy;

    modport master (output rx, input data, num, valid, err, busy);
    modport slave  (input rx, output data, num, valid, err, busy);

endinterface

// File: rtl/uart_frame_rx_urx.sv
// Byte receiver: 2-FF synchroniser, start-edge detect, mid-bit sampling, 8N1 deframing.
module urx
    import uart_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shreg_q;
    logic [7:0]       data_q;
    logic             valid_q, ferr_q;
    logic             bit_tick;

    assign bit_tick = (cnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (rx_prev_q && !rx_sync_q) state_q <= RX_START;
                end
                // Half a bit in: a line that is high again was only a glitch.
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        cnt_q <= '0;
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // Leave at mid-stop-bit so a zero-idle next start edge is not missed.
                RX_STOP: begin
                    if (bit_tick) begin
                        cnt_q   <= '0;
                        valid_q <= rx_sync_q;
                        ferr_q  <= !rx_sync_q;
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RX_DATA && bit_tick) shreg_q <= {rx_sync_q, shreg_q[7:1]};
        if (state_q == RX_STOP && bit_tick && rx_sync_q) data_q <= shreg_q;
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign ferr  = ferr_q;

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: collects payload bytes up to the 0xF0 terminator and
// presents them left-aligned in a 400-bit word with a byte count.
module uart_frame_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int MAX_BYTES = 50
) (
    input  logic            clk_50,
    input  logic            rst_n,
    uart_frame_rx_if.slave  bus
);
    import uart_frame_rx_pkg::*;

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    logic [7:0]         byte_data;
    logic               byte_valid, byte_ferr;

    logic [NUM_W-1:0]   count_q, count_d;
    logic               discard_q, discard_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [FRAME_W-1:0] data_q, frame_d;
    logic [NUM_W-1:0]   num_q;
    logic               wr_en;
    logic [7:0]         buf_q [MAX_BYTES];

    urx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_urx (
        .clk   (clk_50),
        .rst_n (rst_n),
        .rx    (bus.rx),
        .data  (byte_data),
        .valid (byte_valid),
        .ferr  (byte_ferr)
    );

    always_comb begin
        count_d   = count_q;
        discard_d = discard_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        if (byte_ferr) begin
            err_d     = 1'b1;
            discard_d = 1'b1;
            count_d   = '0;
        end else if (byte_valid) begin
            if (byte_data == FRAME_TERM) begin
                // A terminator ends a discarded frame silently; an empty frame is ignored.
                if (discard_q) begin
                    discard_d = 1'b0;
                    count_d   = '0;
                end else if (count_q != '0) begin
                    valid_d = 1'b1;
                    count_d = '0;
                end
            end else if (!discard_q) begin
                if (count_q == NUM_W'(MAX_BYTES)) begin
                    err_d     = 1'b1;
                    discard_d = 1'b1;
                    count_d   = '0;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + NUM_W'(1);
                end
            end
        end
    end

    // Stale buffer entries beyond count are masked so the tail is always zero.
    always_comb begin
        frame_d = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            frame_d[FRAME_W-1-8*k -: 8] = (k < int'(count_q)) ? buf_q[k] : 8'h00;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            discard_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
            num_q     <= '0;
        end else begin
            count_q   <= count_d;
            discard_q <= discard_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            if (valid_d) begin
                data_q <= frame_d;
                num_q  <= count_q;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (wr_en) buf_q[count_q] <= byte_data;
    end

    assign bus.data  = data_q;
    assign bus.num   = num_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.busy  = (count_q != '0) | discard_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames plus randomized frame streams vs. a queue model.
module tb_uart_frame_rx;
    import uart_frame_rx_pkg::*;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 3_125_000;
    localparam int CPB      = CLK_FREQ / BAUD;

    typedef struct {
        bit           is_err;
        logic [5:0]   num;
        logic [399:0] data;
    } ev_t;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;

    uart_frame_rx_if bus();

    uart_frame_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_BYTES(50)) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 clk_50 = ~clk_50;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   both_cnt = 0;
    ev_t  obs_q[$];
    ev_t  exp_q[$];
    logic [7:0] model_buf[$];
    bit   model_discard = 0;

    always @(negedge clk_50) begin
        if (bus.valid && bus.err) both_cnt++;
        if (bus.valid) obs_q.push_back('{1'b0, bus.num, bus.data});
        if (bus.err)   obs_q.push_back('{1'b1, 6'd0, 400'd0});
    end

    // Reference model: frame rules over a byte queue.
    task automatic model_byte(input logic [7:0] b, input bit ferr);
        logic [399:0] d;
        if (ferr) begin
            exp_q.push_back('{1'b1, 6'd0, 400'd0});
            model_discard = 1;
            model_buf.delete();
        end else if (b == 8'hF0) begin
            if (model_discard) begin
                model_discard = 0;
                model_buf.delete();
            end else if (model_buf.size() > 0) begin
                d = '0;
                foreach (model_buf[k]) d = d | ({model_buf[k], 392'd0} >> (8 * k));
                exp_q.push_back('{1'b0, 6'(model_buf.size()), d});
                model_buf.delete();
            end
        end else if (!model_discard) begin
            if (model_buf.size() == 50) begin
                exp_q.push_back('{1'b1, 6'd0, 400'd0});
                model_discard = 1;
                model_buf.delete();
            end else begin
                model_buf.push_back(b);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk_50);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk_50);
        end
        bus.rx = stop;
        repeat (CPB) @(negedge clk_50);
        bus.rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk_50);
        model_byte(b, !stop);
    endtask

    task automatic settle();
        repeat (CPB) @(negedge clk_50);
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [7:0] rand_payload();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'hF0) b = 8'h0F;
        return b;
    endfunction

    function automatic ev_t head(input int idx);
        ev_t none;
        none = '{1'b1, 6'h3F, {400{1'b1}}};
        if (obs_q.size() > idx) return obs_q[idx];
        return none;
    endfunction

    task automatic test_reset();
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (5) @(negedge clk_50);
        n_cmp++; if (bus.data !== 400'd0) begin n_fail++; $display("FAIL reset_data got=%h want=0", bus.data); end
        n_cmp++; if (bus.num !== 6'd0) begin n_fail++; $display("FAIL reset_num got=%0d want=0", bus.num); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", bus.err); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        rst_n = 1'b1;
        model_buf.delete();
        model_discard = 0;
        settle();
    endtask

    task automatic test_basic();
        ev_t e;
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        send_byte(8'h56, 1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid got=%b want=1", bus.busy); end
        send_byte(8'hF0, 1);
        repeat (4) @(negedge clk_50);
        e = head(0);
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL basic_events got=%0d want=1", obs_q.size()); end
        n_cmp++; if (e.is_err !== 1'b0 || e.num !== 6'd3) begin n_fail++; $display("FAIL basic_num got=%0d err=%b want=3", e.num, e.is_err); end
        n_cmp++; if (e.data[399:376] !== 24'h123456) begin n_fail++; $display("FAIL basic_head got=%h want=123456", e.data[399:376]); end
        n_cmp++; if (e.data[375:0] !== 376'd0) begin n_fail++; $display("FAIL basic_tail got=%h want=0", e.data[375:0]); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got=%b want=0", bus.busy); end
        settle();
    endtask

    task automatic test_full();
        ev_t e;
        for (int i = 1; i <= 50; i++) send_byte(8'(i), 1);
        send_byte(8'hF0, 1);
        repeat (4) @(negedge clk_50);
        e = head(0);
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL full_events got=%0d want=1", obs_q.size()); end
        n_cmp++; if (e.num !== 6'd50) begin n_fail++; $display("FAIL full_num got=%0d want=50", e.num); end
        n_cmp++; if (e.data[7:0] !== 8'h32) begin n_fail++; $display("FAIL full_last got=%h want=32", e.data[7:0]); end
        n_cmp++; if (e.data[399:392] !== 8'h01) begin n_fail++; $display("FAIL full_first got=%h want=01", e.data[399:392]); end
        settle();
    endtask

    task automatic test_overflow();
        ev_t e0, e1;
        for (int i = 0; i < 51; i++) send_byte(rand_payload(), 1);
        n_cmp++; if (obs_q.size() !== 1 || head(0).is_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_at_51 got_events=%0d want=1 err", obs_q.size()); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_discard got=%b want=1", bus.busy); end
        send_byte(8'hF0, 1);
        send_byte(8'hAA, 1);
        send_byte(8'hF0, 1);
        repeat (4) @(negedge clk_50);
        e0 = head(0);
        e1 = head(1);
        n_cmp++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL ovf_events got=%0d want=2", obs_q.size()); end
        n_cmp++; if (e1.is_err !== 1'b0 || e1.num !== 6'd1) begin n_fail++; $display("FAIL ovf_next_num got=%0d err=%b want=1", e1.num, e1.is_err); end
        n_cmp++; if (e1.data[399:392] !== 8'hAA) begin n_fail++; $display("FAIL ovf_next_data got=%h want=aa", e1.data[399:392]); end
        n_cmp++; if (e0.is_err !== 1'b1) begin n_fail++; $display("FAIL ovf_first_kind got_err=%b want=1", e0.is_err); end
        settle();
    endtask

    task automatic test_ferr();
        ev_t e0, e1;
        send_byte(8'h55, 0);
        send_byte(8'h77, 1);
        send_byte(8'hF0, 1);
        send_byte(8'h88, 1);
        send_byte(8'hF0, 1);
        repeat (4) @(negedge clk_50);
        e0 = head(0);
        e1 = head(1);
        n_cmp++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL ferr_events got=%0d want=2", obs_q.size()); end
        n_cmp++; if (e0.is_err !== 1'b1) begin n_fail++; $display("FAIL ferr_first got_err=%b want=1", e0.is_err); end
        n_cmp++; if (e1.is_err !== 1'b0 || e1.num !== 6'd1 || e1.data[399:392] !== 8'h88) begin n_fail++; $display("FAIL ferr_next got num=%0d data=%h want num=1 data=88", e1.num, e1.data[399:392]); end
        settle();
    endtask

    task automatic test_glitch();
        bit busy_seen = 0;
        bus.rx = 1'b0;
        repeat (3) @(negedge clk_50);
        bus.rx = 1'b1;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk_50);
            if (bus.busy) busy_seen = 1;
        end
        send_byte(8'hF0, 1);
        repeat (4) @(negedge clk_50);
        n_cmp++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL glitch_events got=%0d want=0", obs_q.size()); end
        n_cmp++; if ((busy_seen | bus.busy) !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got=1 want=0"); end
        settle();
    endtask

    task automatic test_reset_midframe();
        ev_t e;
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
        rst_n = 1'b1;
        model_buf.delete();
        model_discard = 0;
        repeat (3) @(negedge clk_50);
        send_byte(8'h9A, 1);
        send_byte(8'hF0, 1);
        repeat (4) @(negedge clk_50);
        e = head(0);
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL rstmid_events got=%0d want=1", obs_q.size()); end
        n_cmp++; if (e.num !== 6'd1 || e.data[399:392] !== 8'h9A) begin n_fail++; $display("FAIL rstmid_frame got num=%0d data=%h want num=1 data=9a", e.num, e.data[399:392]); end
        settle();
    endtask

    task automatic test_back_to_back();
        int len;
        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) send_byte(rand_payload(), ($urandom_range(0, 15) != 0));
            send_byte(8'hF0, 1);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 40)) @(negedge clk_50);
        end
        repeat (4) @(negedge clk_50);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_events got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].is_err !== exp_q[i].is_err || obs_q[i].num !== exp_q[i].num || obs_q[i].data !== exp_q[i].data)
                begin n_fail++; $display("FAIL b2b_event%0d got err=%b num=%0d want err=%b num=%0d", i, obs_q[i].is_err, obs_q[i].num, exp_q[i].is_err, exp_q[i].num); end
        end
        settle();
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_basic();
        test_full();
        test_overflow();
        test_ferr();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        test_back_to_back();
        n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_err_overlap got=%0d want=0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side counterpart of the team's frame transmitter. It deserialises a UART line at 50 MHz and collects payload bytes until the 0xF0 terminator arrives. It then presents the frame as a left-aligned 400-bit word with a byte count, in the same packing the transmitter's `data`/`num` inputs use. It sits directly behind the board's RX pin and feeds the application logic, or a loop-back into the transmitter.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer-truncated (434 at defaults).
- `MAX_BYTES`, default 50: payload capacity. Must satisfy `8*MAX_BYTES = 400` and `MAX_BYTES < 64`.
- `clk_50`, input, 1: system clock, 50 MHz. This is the block's only clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: UART line. Asynchronous to `clk_50`; idle level is high.
- `data`, output, 400: last good frame. Payload byte k (0-based) is at `data[399-8k -: 8]`. Unused bytes are 0.
- `num`, output, 6: payload byte count of the last good frame, 1..50.
- `valid`, output, 1: one-cycle pulse when `data`/`num` update.
- `err`, output, 1: one-cycle pulse on a framing error or an overflow.
- `busy`, output, 1: high while a frame is partially received or being discarded.

## Operation
- `rx` passes through a 2-FF synchroniser. Both flops reset to 1.
- Byte receiver FSM, with states IDLE, START, DATA, STOP:
  - IDLE to START: on a synchronised high-to-low edge.
  - START: counts `CLKS_PER_BIT/2` cycles, then samples the line. If low, go to DATA; if high (glitch), return to IDLE with no output.
  - DATA: samples 8 bits, each `CLKS_PER_BIT` cycles apart, LSB first.
  - STOP: samples after `CLKS_PER_BIT` cycles. A 1 produces a 1-cycle `byte_valid` carrying `byte`. A 0 produces a 1-cycle `byte_ferr`. Either way the FSM returns to IDLE immediately, at mid-stop-bit.
- Frame assembler, with state `count` (0..50), the buffer, and a `discard` flag:
  - Byte == 0xF0 with `discard` = 0 and `count` > 0: copy the buffer to `data`, set `num` = `count`, pulse `valid`, then clear `count`.
  - Byte == 0xF0 with `count` = 0: ignored. No `valid` is produced.
  - Byte == 0xF0 with `discard` = 1: clear `discard` and `count`. No `valid` is produced.
  - Other byte, `discard` = 0, `count` < 50: store it at index `count`, then increment `count`.
  - Other byte, `count` = 50: overflow. Pulse `err`, set `discard`, clear `count`.
  - Other byte, `discard` = 1: dropped.
  - `byte_ferr`: pulse `err`, set `discard`, clear `count`. A second error while discarding pulses `err` again.
- 0xF0 can never appear as payload. No escape mechanism exists.
- `busy` = (`count` != 0) | `discard`.
- `data` and `num` hold their values until the next `valid`. On `valid` the whole 400-bit word is rewritten, including zeroing the unused tail.

## Timing
- Reset values: `data` = 0, `num` = 0, `valid` = 0, `err` = 0, `busy` = 0. FSM in IDLE, `count` = 0, `discard` = 0.
- Latency from the falling edge of `rx` to `byte_valid` is 2 (synchroniser) + `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` cycles, ±1.
- `valid` and `err` register one cycle after `byte_valid`/`byte_ferr`.
- Back-to-back frames with zero idle are supported: a new start edge is accepted during the second half of the stop bit.
- `valid` and `err` are never high in the same cycle.
- Reset asserted mid-frame clears everything. The partial frame is lost and no pulse is emitted.

## Structure
- Shared package holds:
  - `FRAME_TERM = 8'hF0`, also used by the transmitter;
  - `MAX_BYTES = 50`;
  - `FRAME_W = 400`.
- One sub-module, `urx`, is the byte receiver FSM plus synchroniser. It is the mirror of `utx`, with ports `clk`, `rst_n`, `rx`, `data[7:0]`, `valid`, `ferr`.
- The assembler lives in `uart_frame_rx`. The buffer is written by index; no variable shift of 400 bits on output.

## Test plan
- Bytes 12 34 56 F0 at 115200 baud: one `valid`, `num` = 3, `data[399:376]` = 24'h123456, remaining bits 0, `busy` low afterwards.
- Payload 01..32 hex (50 bytes) followed by F0: `num` = 50, `data[7:0]` = 8'h32.
- 51 non-F0 bytes, F0, then AA F0:
  - one `err` pulse at byte 51;
  - no `valid` for the first frame;
  - then `valid` with `num` = 1, `data[399:392]` = AA.
- Byte 55 sent with stop bit 0, then 77 F0, then 88 F0:
  - `err` once;
  - 77 F0 produces no `valid`;
  - 88 F0 produces `valid` with `num` = 1.
- 1 µs low glitch on `rx`, followed by a lone F0: no `valid`, no `err`, `busy` stays low.
- Reset pulse after 2 bytes of a frame, then 9A F0: `valid` with `num` = 1, `data[399:392]` = 9A.
